// File: rtl/matriz_multiplicacao_seq_pkg.sv
// rtl/matriz_multiplicacao_seq_pkg.sv - shared FSM encoding and width helpers for matrix blocks
package matriz_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_FIN  = 2'd2;

  // Accumulator width that holds a full n-term dot product of signed width-bit operands
  function automatic int acc_width(input int n, input int width);
    return 2 * width + $clog2(n) + 1;
  endfunction

  // Index counter width for 0..n-1, at least one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matriz_multiplicacao_seq_if.sv
// rtl/matriz_multiplicacao_seq_if.sv - operand/result bundle between register bank and multiplier
interface matriz_multiplicacao_seq_if #(
  parameter int N     = 3,
  parameter int WIDTH = 8,
  parameter int OUT_W = 2 * WIDTH + 3
);

  localparam int TW = $clog2(N + 1);

  logic                     start;
  logic [TW-1:0]            tamanho;
  logic [N*N*WIDTH-1:0]     A;
  logic [N*N*WIDTH-1:0]     B;
  logic                     busy;
  logic                     done;
  logic [N*N*OUT_W-1:0]     Resultado;
  logic                     overflow;

  modport master (
    output start, tamanho, A, B,
    input  busy, done, Resultado, overflow
  );

  modport slave (
    input  start, tamanho, A, B,
    output busy, done, Resultado, overflow
  );

endinterface

// File: rtl/matriz_multiplicacao_seq_mac.sv
// rtl/matriz_multiplicacao_seq_mac.sv - signed multiply-accumulate with clear-on-first-term
module matriz_mac
  import matriz_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2 * WIDTH + 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [ACC_W-1:0] acc_next
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   acc_d;

  // Product plus the running sum, restarted when the first term of a dot product arrives
  always_comb begin
    prod     = a * b;
    acc_next = (clr ? '0 : acc_q) + ACC_W'(prod);
    acc_d    = en ? acc_next : acc_q;
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matriz_multiplicacao_seq.sv
// rtl/matriz_multiplicacao_seq.sv - sequential signed NxN matrix multiplier; MATRIZ_SAT_EN selects saturating output
module matriz_multiplicacao_seq
  import matriz_pkg::*;
#(
  parameter int N     = 3,
  parameter int WIDTH = 8,
  parameter int OUT_W = 2 * WIDTH + 3
) (
  input  logic                       clk,
  input  logic                       rst,
  matriz_multiplicacao_seq_if.slave  bus
);

  localparam int ACC_W = acc_width(N, WIDTH);
  localparam int IW    = idx_width(N);
  localparam int TW    = $clog2(N + 1);
  localparam int EW    = (ACC_W > OUT_W) ? ACC_W : OUT_W;

  localparam logic signed [EW-1:0] MAX_V = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_V = ~MAX_V;

  state_t                 state_q, state_d;
  logic [IW-1:0]          i_q, i_d;
  logic [IW-1:0]          j_q, j_d;
  logic [IW-1:0]          k_q, k_d;
  logic [TW-1:0]          n_q, n_d;
  logic [N*N*WIDTH-1:0]   a_q, a_d;
  logic [N*N*WIDTH-1:0]   b_q, b_d;
  logic [N*N*OUT_W-1:0]   res_q, res_d;
  logic                   ovf_q, ovf_d;

  logic [TW-1:0]          n_clamp;
  logic                   k_last, j_last, i_last;
  int                     a_base, b_base, r_base;
  logic signed [WIDTH-1:0] a_sel, b_sel;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [EW-1:0]   acc_ext;
  logic                   elem_hi, elem_lo, elem_ovf;
  logic [OUT_W-1:0]       elem_out;

  matriz_mac #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .en       (state_q == ST_CALC),
    .clr      (k_q == '0),
    .a        (a_sel),
    .b        (b_sel),
    .acc_next (acc_next)
  );

  // Operand selection, loop-end detection and conversion of the finished dot product to OUT_W
  always_comb begin
    n_clamp  = (bus.tamanho == '0 || int'(bus.tamanho) > N) ? TW'(N) : bus.tamanho;
    k_last   = (int'(k_q) == int'(n_q) - 1);
    j_last   = (int'(j_q) == int'(n_q) - 1);
    i_last   = (int'(i_q) == int'(n_q) - 1);
    a_base   = (int'(i_q) * N + int'(k_q)) * WIDTH;
    b_base   = (int'(k_q) * N + int'(j_q)) * WIDTH;
    r_base   = (int'(i_q) * N + int'(j_q)) * OUT_W;
    a_sel    = a_q[a_base +: WIDTH];
    b_sel    = b_q[b_base +: WIDTH];
    acc_ext  = EW'(acc_next);
    elem_hi  = (acc_ext > MAX_V);
    elem_lo  = (acc_ext < MIN_V);
    elem_ovf = elem_hi | elem_lo;
`ifdef MATRIZ_SAT_EN
    if (elem_hi) begin
      elem_out = MAX_V[OUT_W-1:0];
    end else if (elem_lo) begin
      elem_out = MIN_V[OUT_W-1:0];
    end else begin
      elem_out = acc_ext[OUT_W-1:0];
    end
`else
    elem_out = acc_ext[OUT_W-1:0];
`endif
  end

  // FSM: latch operands on start, walk k innermost then j then i, one MAC per cycle
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    n_d     = n_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          n_d     = n_clamp;
          res_d   = '0;
          ovf_d   = 1'b0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (k_last) begin
          k_d                   = '0;
          res_d[r_base +: OUT_W] = elem_out;
          ovf_d                 = ovf_q | elem_ovf;
          if (j_last) begin
            j_d = '0;
            if (i_last) begin
              i_d     = '0;
              state_d = ST_FIN;
            end else begin
              i_d = i_q + IW'(1);
            end
          end else begin
            j_d = j_q + IW'(1);
          end
        end else begin
          k_d = k_q + IW'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, operand latches and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      n_q     <= n_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy      = (state_q == ST_CALC);
  assign bus.done      = (state_q == ST_FIN);
  assign bus.Resultado = res_q;
  assign bus.overflow  = ovf_q;

endmodule
